// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute, with stall and flush support.
// Define DECODE_SKID_BUF_EN to add a 1-entry skid buffer and drive in_ready_o from a flop.
module decode_stage #(
  parameter int XLEN          = 32,
  parameter int PC_WIDTH      = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_instr_i,
  input  logic [PC_WIDTH-1:0]      in_pc_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PC_WIDTH-1:0]      out_pc_o,
  output logic [REG_IDX_WIDTH-1:0] out_rs1_idx_o,
  output logic [REG_IDX_WIDTH-1:0] out_rs2_idx_o,
  output logic [REG_IDX_WIDTH-1:0] out_rd_idx_o,
  output logic                     out_rs1_en_o,
  output logic                     out_rs2_en_o,
  output logic                     out_rd_en_o,
  output logic [XLEN-1:0]          out_imm_o,
  output logic [2:0]               out_fun3_o,
  output logic [6:0]               out_fun7_o,
  output logic [8:0]               out_class_o,
  output logic                     out_illegal_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a presented bundle is held stable until it transfers.

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [PC_WIDTH-1:0]      pc;
    logic [REG_IDX_WIDTH-1:0] rs1;
    logic [REG_IDX_WIDTH-1:0] rs2;
    logic [REG_IDX_WIDTH-1:0] rd;
    logic                     rs1_en;
    logic                     rs2_en;
    logic                     rd_en;
    logic [XLEN-1:0]          imm;
    logic [2:0]               fun3;
    logic [6:0]               fun7;
    logic [8:0]               cls;
    logic                     illegal;
  } bundle_t;

  bundle_t   dec;
  bundle_t   out_q, out_d;
  logic      out_valid_q, out_valid_d;
  logic      accept;
  logic      legal;
  logic [6:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr_i[6:0];
  assign fun3   = in_instr_i[14:12];
  assign fun7   = in_instr_i[31:25];

  assign imm_i = XLEN'($signed(in_instr_i[31:20]));
  assign imm_s = XLEN'($signed({in_instr_i[31:25], in_instr_i[11:7]}));
  assign imm_b = XLEN'($signed({in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                                in_instr_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                                in_instr_i[30:21], 1'b0}));

  always_comb begin
    dec         = '0;
    legal       = 1'b0;
    dec.pc      = in_pc_i;
    dec.rs1     = REG_IDX_WIDTH'(in_instr_i[19:15]);
    dec.rs2     = REG_IDX_WIDTH'(in_instr_i[24:20]);
    dec.rd      = REG_IDX_WIDTH'(in_instr_i[11:7]);
    dec.fun3    = fun3;
    dec.fun7    = fun7;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal     = 1'b1;
        dec.cls   = (opcode == OPC_LUI) ? 9'b0_0000_0001 : 9'b0_0000_0010;
        dec.rd_en = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_JAL: begin
        legal     = 1'b1;
        dec.cls   = 9'b0_0000_0100;
        dec.rd_en = 1'b1;
        dec.imm   = imm_j;
      end
      OPC_JALR: begin
        legal      = (fun3 == 3'b000);
        dec.cls    = 9'b0_0000_1000;
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_i;
      end
      OPC_BRANCH: begin
        legal      = (fun3 != 3'b010) && (fun3 != 3'b011);
        dec.cls    = 9'b0_0001_0000;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.imm    = imm_b;
      end
      OPC_LOAD: begin
        legal      = (fun3 != 3'b011) && (fun3 != 3'b110) && (fun3 != 3'b111);
        dec.cls    = 9'b0_0010_0000;
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_i;
      end
      OPC_STORE: begin
        legal      = (fun3 == 3'b000) || (fun3 == 3'b001) || (fun3 == 3'b010);
        dec.cls    = 9'b0_0100_0000;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.imm    = imm_s;
      end
      OPC_OP_IMM: begin
        legal      = 1'b1;
        dec.cls    = 9'b0_1000_0000;
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_i;
      end
      OPC_OP: begin
        legal      = (fun7 == 7'b0000000) || (fun7 == 7'b0100000);
        dec.cls    = 9'b1_0000_0000;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.rd_en  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (in_instr_i[1:0] != 2'b11) legal = 1'b0;
    // Illegal bundles still travel down the pipe so execute can raise the trap.
    if (!legal) begin
      dec.cls     = '0;
      dec.rs1_en  = 1'b0;
      dec.rs2_en  = 1'b0;
      dec.rd_en   = 1'b0;
      dec.imm     = '0;
      dec.illegal = 1'b1;
    end
    if (dec.rd == '0) dec.rd_en = 1'b0;
  end

  assign accept = in_valid_i & in_ready_o;

`ifdef DECODE_SKID_BUF_EN
  bundle_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;

  assign in_ready_o = ~skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      // Output slot frees up this cycle; the older skid entry always goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready_o = ~out_valid_q | out_ready_i;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_pc_o      = out_q.pc;
  assign out_rs1_idx_o = out_q.rs1;
  assign out_rs2_idx_o = out_q.rs2;
  assign out_rd_idx_o  = out_q.rd;
  assign out_rs1_en_o  = out_q.rs1_en;
  assign out_rs2_en_o  = out_q.rs2_en;
  assign out_rd_en_o   = out_q.rd_en;
  assign out_imm_o     = out_q.imm;
  assign out_fun3_o    = out_q.fun3;
  assign out_fun7_o    = out_q.fun7;
  assign out_class_o   = out_q.cls;
  assign out_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, hold/skid, flush and async reset sequences.
// Expectations follow DECODE_SKID_BUF_EN when the bench is built with it defined.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [31:0] in_pc_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [4:0]  out_rs1_idx_o, out_rs2_idx_o, out_rd_idx_o;
  logic        out_rs1_en_o, out_rs2_en_o, out_rd_en_o;
  logic [31:0] out_imm_o;
  logic [2:0]  out_fun3_o;
  logic [6:0]  out_fun7_o;
  logic [8:0]  out_class_o;
  logic        out_illegal_o;

`ifdef DECODE_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_rs1_idx_o(out_rs1_idx_o), .out_rs2_idx_o(out_rs2_idx_o), .out_rd_idx_o(out_rd_idx_o),
    .out_rs1_en_o(out_rs1_en_o), .out_rs2_en_o(out_rs2_en_o), .out_rd_en_o(out_rd_en_o),
    .out_imm_o(out_imm_o), .out_fun3_o(out_fun3_o), .out_fun7_o(out_fun7_o),
    .out_class_o(out_class_o), .out_illegal_o(out_illegal_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int sb_pops  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: PCs of accepted bundles must come out in order, once each.
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        sb_pops++;
        if (exp_q.size() == 0) check("sb_unexpected", {32'd0, out_pc_o}, 64'hDEAD);
        else check("sb_order", {32'd0, out_pc_o}, {32'd0, exp_q.pop_front()});
      end
      if (flush_i) exp_q.delete();
      else if (in_valid_i && in_ready_o) exp_q.push_back(in_pc_i);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    bit acc;
    bit done = 1'b0;
    in_valid_i = 1'b1;
    in_instr_i = instr;
    in_pc_i    = pc;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk_i);
      acc = in_ready_o && !flush_i;
      @(posedge clk_i);
      #1;
      done = acc;
    end
    if (!done) check("drv_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [14:0] idx;   // {rs1, rs2, rd}
    logic [2:0]  en;    // {rs1_en, rs2_en, rd_en}
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [8:0]  cls;
    logic        ill;
  } vec_t;

  vec_t vecs[14];
  bit   drv_done;
  int   pops0;

  initial begin
    vecs[0]  = '{32'hFFF10093, 32'h100, {5'd2, 5'd31, 5'd1}, 3'b101, 32'hFFFFFFFF, 3'd0, 7'h7F, 9'h080, 1'b0};
    vecs[1]  = '{32'h002081B3, 32'h104, {5'd1, 5'd2, 5'd3},  3'b111, 32'h00000000, 3'd0, 7'h00, 9'h100, 1'b0};
    vecs[2]  = '{32'h123452B7, 32'h108, {5'd8, 5'd3, 5'd5},  3'b001, 32'h12345000, 3'd5, 7'h09, 9'h001, 1'b0};
    vecs[3]  = '{32'h0020A423, 32'h10C, {5'd1, 5'd2, 5'd8},  3'b110, 32'h00000008, 3'd2, 7'h00, 9'h040, 1'b0};
    vecs[4]  = '{32'h0000006F, 32'h110, {5'd0, 5'd0, 5'd0},  3'b000, 32'h00000000, 3'd0, 7'h00, 9'h004, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h114, {5'd0, 5'd0, 5'd0},  3'b000, 32'h00000000, 3'd0, 7'h00, 9'h000, 1'b1};
    vecs[6]  = '{32'hFE000EE3, 32'h118, {5'd0, 5'd0, 5'd29}, 3'b110, 32'hFFFFFFFC, 3'd0, 7'h7F, 9'h010, 1'b0};
    vecs[7]  = '{32'h000010E7, 32'h11C, {5'd0, 5'd0, 5'd1},  3'b000, 32'h00000000, 3'd1, 7'h00, 9'h000, 1'b1};
    vecs[8]  = '{32'h022081B3, 32'h120, {5'd1, 5'd2, 5'd3},  3'b000, 32'h00000000, 3'd0, 7'h01, 9'h000, 1'b1};
    vecs[9]  = '{32'h00008067, 32'h124, {5'd1, 5'd0, 5'd0},  3'b100, 32'h00000000, 3'd0, 7'h00, 9'h008, 1'b0};
    vecs[10] = '{32'hFFFFF117, 32'h128, {5'd31, 5'd31, 5'd2}, 3'b001, 32'hFFFFF000, 3'd7, 7'h7F, 9'h002, 1'b0};
    vecs[11] = '{32'h00012283, 32'h12C, {5'd2, 5'd0, 5'd5},  3'b101, 32'h00000000, 3'd2, 7'h00, 9'h020, 1'b0};
    vecs[12] = '{32'h8000006F, 32'h130, {5'd0, 5'd0, 5'd0},  3'b000, 32'hFFF00000, 3'd0, 7'h40, 9'h004, 1'b0};
    vecs[13] = '{32'h00002063, 32'h134, {5'd0, 5'd0, 5'd0},  3'b000, 32'h00000000, 3'd2, 7'h00, 9'h000, 1'b1};

    // ---- reset state ----
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_ready", {63'd0, in_ready_o}, 64'd1);
    check("rst_bundle", {out_pc_o, out_imm_o}, 64'd0);
    check("rst_misc", {out_rs1_idx_o, out_rs2_idx_o, out_rd_idx_o, out_rs1_en_o, out_rs2_en_o,
                       out_rd_en_o, out_fun3_o, out_fun7_o, out_class_o, out_illegal_o}, 64'd0);
    rst_i = 1'b0;

    // ---- back-to-back table stream, one vector per cycle ----
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid_i = 1'b1;
      in_instr_i = vecs[i].instr;
      in_pc_i    = vecs[i].pc;
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_valid", i), {63'd0, out_valid_o}, 64'd1);
      check($sformatf("v%0d_pc", i), {32'd0, out_pc_o}, {32'd0, vecs[i].pc});
      check($sformatf("v%0d_idx", i), {49'd0, out_rs1_idx_o, out_rs2_idx_o, out_rd_idx_o},
            {49'd0, vecs[i].idx});
      check($sformatf("v%0d_en", i), {61'd0, out_rs1_en_o, out_rs2_en_o, out_rd_en_o},
            {61'd0, vecs[i].en});
      check($sformatf("v%0d_imm", i), {32'd0, out_imm_o}, {32'd0, vecs[i].imm});
      check($sformatf("v%0d_fun", i), {54'd0, out_fun3_o, out_fun7_o}, {54'd0, vecs[i].f3, vecs[i].f7});
      check($sformatf("v%0d_cls", i), {54'd0, out_class_o, out_illegal_o}, {54'd0, vecs[i].cls, vecs[i].ill});
    end
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("drain_valid", {63'd0, out_valid_o}, 64'd0);

    // ---- hold for 3 cycles with input pending, then release ----
    pops0       = sb_pops;
    drv_done    = 1'b0;
    out_ready_i = 1'b0;
    fork
      begin
        send(32'h00100093, 32'h200);
        send(32'h00200113, 32'h204);
        send(32'h00300193, 32'h208);
        in_valid_i = 1'b0;
        drv_done   = 1'b1;
      end
    join_none
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("hold%0d_valid", c), {63'd0, out_valid_o}, 64'd1);
      check($sformatf("hold%0d_pc", c), {32'd0, out_pc_o}, 64'h200);
      check($sformatf("hold%0d_imm", c), {32'd0, out_imm_o}, 64'd1);
      check($sformatf("hold%0d_ready", c), {63'd0, in_ready_o}, {63'd0, (SKID && c == 0)});
    end
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_i);
      if (drv_done && exp_q.size() == 0 && !out_valid_o) break;
    end
    check("hold_drained", {63'd0, (drv_done && exp_q.size() == 0 && !out_valid_o)}, 64'd1);
    check("hold_count", 64'(sb_pops - pops0), 64'd3);

    // ---- flush while streaming: incoming handshake is dropped ----
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00500293;
    in_pc_i    = 32'h300;
    @(posedge clk_i);
    #1;
    in_instr_i = 32'h00600313;
    in_pc_i    = 32'h304;
    flush_i    = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_a_valid", {63'd0, out_valid_o}, 64'd0);

    // ---- flush while stalled (skid occupied when present) ----
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00700393;
    in_pc_i     = 32'h400;
    @(posedge clk_i);
    #1;
    in_instr_i = 32'h00800413;
    in_pc_i    = 32'h404;
    @(posedge clk_i);
    #1;
    check("flush_b_pre", {32'd0, out_pc_o}, 64'h400);
    in_instr_i = 32'h00900493;
    in_pc_i    = 32'h408;
    flush_i    = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    check("flush_b_valid", {63'd0, out_valid_o}, 64'd0);
    check("flush_b_ready", {63'd0, in_ready_o}, 64'd1);
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("flush_b_stays", {63'd0, out_valid_o}, 64'd0);
    send(32'h00A00513, 32'h500);
    in_valid_i = 1'b0;
    check("recover_pc", {32'd0, out_pc_o}, 64'h500);
    check("recover_imm", {32'd0, out_imm_o}, 64'd10);

    // ---- asynchronous reset mid-stream ----
    in_valid_i = 1'b1;
    in_instr_i = 32'hFFF10093;
    in_pc_i    = 32'h600;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    check("arst_pre", {32'd0, out_pc_o}, 64'h600);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid_o}, 64'd0);
    check("arst_bundle", {out_pc_o, out_imm_o}, 64'd0);
    check("arst_misc", {out_rs1_idx_o, out_rd_idx_o, out_rs1_en_o, out_rd_en_o, out_class_o}, 64'd0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst_valid", {63'd0, out_valid_o}, 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I decode stage that sits between fetch and execute, generalising the combinational decoder into a pipeline stage. It takes one instruction and PC per valid/ready handshake and produces register indices, read/write enables, a sign-extended immediate, a one-hot instruction class and an illegal-instruction flag. Outputs are registered and held until execute accepts them. The stage supports stall (back-pressure) and flush (branch redirect).

Parameters:
XLEN, 32, datapath and immediate width (>=32); immediates sign-extend to XLEN
PC_WIDTH, 32, width of PC carried alongside the instruction
REG_IDX_WIDTH, 5, register index width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
in_valid_i  in  1  fetch presents instruction
in_ready_o  out  1  stage can accept
in_instr_i  in  32  instruction word
in_pc_i  in  PC_WIDTH  instruction PC
flush_i  in  1  discard held and incoming instruction
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  execute accepts bundle
out_pc_o  out  PC_WIDTH  PC of decoded instruction
out_rs1_idx_o / out_rs2_idx_o / out_rd_idx_o  out  REG_IDX_WIDTH  instr[19:15] / [24:20] / [11:7]
out_rs1_en_o / out_rs2_en_o / out_rd_en_o  out  1  read rs1 / read rs2 / write rd
out_imm_o  out  XLEN  immediate
out_fun3_o  out  3  instr[14:12]
out_fun7_o  out  7  instr[31:25]
out_class_o  out  9  one-hot: [0]LUI [1]AUIPC [2]JAL [3]JALR [4]BRANCH [5]LOAD [6]STORE [7]OP_IMM [8]OP
out_illegal_o  out  1  unrecognised instruction

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0; every other output register = 0; skid entry empty.
- Accept = in_valid_i & in_ready_o. Without skid: in_ready_o = ~out_valid_o | out_ready_i (combinational).
- Latency 1: bundle accepted at edge N appears on outputs after edge N; out_valid_o=1 from then on.
- Hold: out_valid_o=1 & out_ready_i=0 -> all outputs stable; no new accept.
- Consume and refill in the same cycle (out_ready_i=1, accept=1) -> next bundle loads; out_valid_o stays 1, no bubble.
- Consume without accept -> out_valid_o=0 next cycle.
- flush_i=1 -> out_valid_o=0 next cycle; the input in the flush cycle is dropped, even if its handshake completes. Flush has priority over hold and accept. Data registers need not be cleared.
- Opcodes (instr[6:0]) and the fields they drive:
  - 0110111 LUI: rd_en; imm = {instr[31:12], 12'b0} sign-extended.
  - 0010111 AUIPC: same fields as LUI.
  - 1101111 JAL: rd_en; J-imm.
  - 1100111 JALR (fun3=000): rs1_en, rd_en; I-imm.
  - 1100011 BRANCH (fun3 not 010/011): rs1_en, rs2_en; B-imm.
  - 0000011 LOAD (fun3 in 000,001,010,100,101): rs1_en, rd_en; I-imm.
  - 0100011 STORE (fun3 in 000,001,010): rs1_en, rs2_en; S-imm.
  - 0010011 OP_IMM: rs1_en, rd_en; I-imm.
  - 0110011 OP (fun7 in 0000000/0100000): rs1_en, rs2_en, rd_en; imm=0.
- out_rd_en_o is forced 0 when rd==0.
- Illegal when any of these holds: instr[1:0]!=11, unknown opcode, or fun3/fun7 outside the listed sets. Illegal -> out_illegal_o=1, class=0, all enables=0, imm=0; out_valid_o still asserts so execute can trap.
- Index outputs always carry the raw instruction fields regardless of enables.

Optional Feature:
DECODE_SKID_BUF_EN
- Defined: in_ready_o is driven directly from a flop.
  - A 1-entry skid buffer captures the bundle accepted while the output is stalled.
  - in_ready_o = skid empty. When the output drains, the skid entry moves to the output in the next cycle.
  - flush_i empties both the skid and the output.
  - Ordering is preserved; throughput is 1/cycle.
- Undefined: no skid buffer; in_ready_o is combinational as above.

Test Plan:
- 0xFFF10093 (addi x1,x2,-1), PC 0x100, out_ready_i=1 -> next cycle: rs1=2, rd=1, rs1_en=1, rs2_en=0, rd_en=1, imm=0xFFFFFFFF, class=OP_IMM, pc=0x100.
- 0x002081B3 (add x3,x1,x2) -> rs1=1, rs2=2, rd=3, all three enables=1, imm=0, class=OP.
- Sequence 0x123452B7 (lui) then 0x0020A423 (sw x2,8(x1)) -> imm=0x12345000, rd=5; then imm=8, rs1_en=1, rs2_en=1, rd_en=0.
- 0x0000006F (jal x0) -> rd_en=0, imm=0, class=JAL. 0x00000000 -> illegal=1, enables=0, out_valid_o=1.
- Hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> outputs frozen, in_ready_o=0 (with skid: one extra accept, then 0). Release -> in-order delivery, no loss or duplication.
- Assert flush_i during an accept while stalled -> out_valid_o=0 next cycle, dropped instruction never appears. Assert rst_i mid-stream -> all outputs 0 immediately (async).
